// File: rtl/ddr_tx.sv
// HDR-DDR transmit serializer: shifts single bits, data words, parity, CRC token or CRC5 onto SDA,
// one bit per SCL edge (either polarity), and keeps a running CRC5 over transmitted data words.
module ddr_tx #(
  parameter int         WORD_W   = 16,
  parameter logic [4:0] CRC_INIT = 5'h1F
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sclgen_scl_pos_edge,
  input  logic              i_sclgen_scl_neg_edge,
  input  logic              i_ddrccc_tx_en,
  input  logic [3:0]        i_ddrccc_tx_mode,
  input  logic              i_ddrccc_tx_bit,
  input  logic              i_ddrccc_crc_init,
  input  logic [WORD_W-1:0] i_regf_tx_word,
  output logic              o_sdahnd_tx_sda,
  output logic              o_sdahnd_tx_oe,
  output logic              o_ddrccc_tx_mode_done,
  output logic              o_ddrccc_error
);
  localparam int         CNT_W    = $clog2(WORD_W + 1);
  localparam logic [3:0] M_SINGLE = 4'b0000;
  localparam logic [3:0] M_WORD   = 4'b0011;
  localparam logic [3:0] M_PARITY = 4'b0110;
  localparam logic [3:0] M_TOKEN  = 4'b1000;
  localparam logic [3:0] M_CRC    = 4'b1001;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] shreg, word_q;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        crc;
  logic              data_mode, err;
  logic              legal, start, strobe, consume, fb, pa1, pa0;

  assign legal   = (i_ddrccc_tx_mode == M_SINGLE) || (i_ddrccc_tx_mode == M_WORD) ||
                   (i_ddrccc_tx_mode == M_PARITY) || (i_ddrccc_tx_mode == M_TOKEN) ||
                   (i_ddrccc_tx_mode == M_CRC);
  assign start   = i_ddrccc_tx_en && legal && (state == IDLE || state == DONE);
  // Coincident SCL strobes count as a single edge.
  assign strobe  = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign consume = (state == SHIFT) && i_ddrccc_tx_en && strobe;
  assign fb      = crc[4] ^ shreg[WORD_W-1];

  // Parity is taken from the last word that was latched for transmission.
  always_comb begin
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int i = 0; i < WORD_W; i++) begin
      if (i % 2 == 1) pa1 = pa1 ^ word_q[i];
      else            pa0 = pa0 ^ word_q[i];
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = i_ddrccc_tx_en ? SHIFT : IDLE;
      SHIFT: begin
        if (!i_ddrccc_tx_en)                      state_nxt = IDLE;
        else if (strobe && cnt == CNT_W'(1))      state_nxt = DONE;
      end
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      shreg     <= '0;
      word_q    <= '0;
      cnt       <= '0;
      crc       <= CRC_INIT;
      data_mode <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= i_ddrccc_tx_en && !legal && (state == IDLE || state == DONE);
      if (start) begin
        data_mode <= (i_ddrccc_tx_mode == M_WORD);
        case (i_ddrccc_tx_mode)
          M_WORD: begin
            shreg  <= i_regf_tx_word;
            word_q <= i_regf_tx_word;
            cnt    <= CNT_W'(WORD_W);
          end
          M_PARITY: begin
            shreg <= {pa1, pa0, {(WORD_W-2){1'b0}}};
            cnt   <= CNT_W'(2);
          end
          M_TOKEN: begin
            shreg <= {4'b1100, {(WORD_W-4){1'b0}}};
            cnt   <= CNT_W'(4);
          end
          M_CRC: begin
            shreg <= {crc, {(WORD_W-5){1'b0}}};
            cnt   <= CNT_W'(5);
          end
          default: begin
            shreg <= {i_ddrccc_tx_bit, {(WORD_W-1){1'b0}}};
            cnt   <= CNT_W'(1);
          end
        endcase
      end else if (consume && cnt > CNT_W'(1)) begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
        cnt   <= cnt - CNT_W'(1);
      end
      // The last bit stays in place so DONE keeps driving it.
      if (i_ddrccc_crc_init)          crc <= CRC_INIT;
      else if (consume && data_mode)  crc <= {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
  end

  always_comb begin
    o_sdahnd_tx_sda       = 1'b1;
    o_sdahnd_tx_oe        = 1'b0;
    o_ddrccc_tx_mode_done = 1'b0;
    o_ddrccc_error        = err;
    case (state)
      LOAD, SHIFT: begin
        o_sdahnd_tx_sda = shreg[WORD_W-1];
        o_sdahnd_tx_oe  = 1'b1;
      end
      DONE: begin
        o_sdahnd_tx_sda       = shreg[WORD_W-1];
        o_sdahnd_tx_oe        = 1'b1;
        o_ddrccc_tx_mode_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ddr_tx.sv
// Bench for ddr_tx: directed vector table, hand-written abort/reset/error sequences,
// and randomized mode sequences checked against a spec-level model of bits, parity and CRC5.
module tb_ddr_tx;
  logic        clk = 1'b0;
  logic        rst, pos, neg, en, tx_bit, crc_init;
  logic [3:0]  mode;
  logic [15:0] word;
  logic        sda, oe, done, err;

  always #10 clk = ~clk;

  ddr_tx dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst),
    .i_sclgen_scl_pos_edge(pos),
    .i_sclgen_scl_neg_edge(neg),
    .i_ddrccc_tx_en       (en),
    .i_ddrccc_tx_mode     (mode),
    .i_ddrccc_tx_bit      (tx_bit),
    .i_ddrccc_crc_init    (crc_init),
    .i_regf_tx_word       (word),
    .o_sdahnd_tx_sda      (sda),
    .o_sdahnd_tx_oe       (oe),
    .o_ddrccc_tx_mode_done(done),
    .o_ddrccc_error       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: running CRC5 and the last word handed to the serializer.
  logic [4:0]  m_crc;
  logic [15:0] m_word;

  typedef struct {
    logic [3:0]  mode;
    logic        b;
    logic [15:0] w;
    int          n;
    logic [15:0] bits;
    logic        keep;
  } vec_t;
  vec_t tbl[9];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic e_sda, input logic e_oe,
                           input logic e_done, input logic e_err);
    check1({tag, ".sda"},  sda,  e_sda);
    check1({tag, ".oe"},   oe,   e_oe);
    check1({tag, ".done"}, done, e_done);
    check1({tag, ".err"},  err,  e_err);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] crc_bit(input logic [4:0] c, input logic d);
    logic f;
    f = c[4] ^ d;
    return {c[3:0], 1'b0} ^ (f ? 5'b00101 : 5'b00000);
  endfunction

  task automatic model_expect(input logic [3:0] m, input logic b, input logic [15:0] w,
                              output int n, output logic [15:0] bits);
    int odd_ones, even_ones;
    odd_ones  = 0;
    even_ones = 0;
    for (int k = 0; k < 16; k++)
      if (m_word[k]) begin
        if (k % 2 == 1) odd_ones++;
        else            even_ones++;
      end
    case (m)
      4'd0:    begin n = 1;  bits = {b, 15'b0}; end
      4'd3:    begin n = 16; bits = w; end
      4'd6:    begin n = 2;  bits = {(odd_ones % 2 == 1), (even_ones % 2 == 0), 14'b0}; end
      4'd8:    begin n = 4;  bits = 16'hC000; end
      4'd9:    begin n = 5;  bits = {m_crc, 11'b0}; end
      default: begin n = 0;  bits = 16'h0; end
    endcase
  endtask

  task automatic model_commit(input logic [3:0] m, input logic [15:0] w, input int nbits);
    if (m == 4'd3) begin
      m_word = w;
      for (int k = 15; k > 15 - nbits; k--) m_crc = crc_bit(m_crc, w[k]);
    end
  endtask

  // Enter from IDLE or DONE; leaves the DUT in DONE with tx_en = keep_en.
  task automatic do_mode(input logic [3:0] m, input logic b, input logic [15:0] w, input int n,
                         input logic [15:0] bits, input logic keep_en);
    mode = m; tx_bit = b; word = w; en = 1'b1;
    tick;
    check_out("load", bits[15], 1'b1, 1'b0, 1'b0);
    word = ~w; tx_bit = ~b; mode = 4'($urandom);
    {pos, neg} = 2'($urandom_range(0, 3));
    tick;
    pos = 1'b0; neg = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        check_out("hold", bits[15-i], 1'b1, 1'b0, 1'b0);
        tick;
      end
      check_out("bit", bits[15-i], 1'b1, 1'b0, 1'b0);
      {pos, neg} = 2'($urandom_range(1, 3));
      tick;
      pos = 1'b0; neg = 1'b0;
    end
    check_out("done", bits[16-n], 1'b1, 1'b1, 1'b0);
    if (!keep_en) en = 1'b0;
  endtask

  initial begin
    int          n;
    logic [15:0] bits;
    logic [3:0]  m;
    logic        keep;
    logic [15:0] w;

    rst = 1'b1; pos = 1'b0; neg = 1'b0; en = 1'b0; tx_bit = 1'b0;
    crc_init = 1'b0; mode = 4'd0; word = 16'h0;
    m_crc = 5'h1F; m_word = 16'h0;
    tick; tick;
    check_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;

    crc_init = 1'b1; tick; crc_init = 1'b0;
    m_crc = 5'h1F;

    tbl[0] = '{4'd3, 1'b0, 16'h0000, 16, 16'h0000, 1'b1};
    tbl[1] = '{4'd6, 1'b0, 16'h0000, 2,  16'h4000, 1'b0};
    tbl[2] = '{4'd8, 1'b0, 16'h0000, 4,  16'hC000, 1'b1};
    tbl[3] = '{4'd9, 1'b0, 16'h0000, 5,  16'h0800, 1'b0};
    tbl[4] = '{4'd3, 1'b0, 16'hADCA, 16, 16'hADCA, 1'b1};
    tbl[5] = '{4'd6, 1'b0, 16'h0000, 2,  16'h0000, 1'b0};
    tbl[6] = '{4'd0, 1'b0, 16'h0000, 1,  16'h0000, 1'b0};
    tbl[7] = '{4'd0, 1'b1, 16'h0000, 1,  16'h8000, 1'b1};
    tbl[8] = '{4'd8, 1'b0, 16'h0000, 4,  16'hC000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_mode(tbl[i].mode, tbl[i].b, tbl[i].w, tbl[i].n, tbl[i].bits, tbl[i].keep);
      model_commit(tbl[i].mode, tbl[i].w, 16);
      if (!tbl[i].keep) begin
        tick;
        check_out("tbl_idle", 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end

    // Illegal mode: one error pulse, block never drives SDA.
    en = 1'b1; mode = 4'b0101;
    tick;
    check_out("illegal", 1'b1, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    tick;
    check_out("illegal_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after 5 strobes: no done, CRC keeps the 5 bits already sent.
    w = 16'h9C35;
    mode = 4'd3; word = w; en = 1'b1;
    tick; tick;
    for (int k = 0; k < 5; k++) begin
      check1("abort_bit", sda, w[15-k]);
      pos = 1'b1; tick; pos = 1'b0;
    end
    en = 1'b0;
    tick;
    check_out("abort", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin tick; check1("abort_nodone", done, 1'b0); end
    model_commit(4'd3, w, 5);
    model_expect(4'd9, 1'b0, 16'h0, n, bits);
    do_mode(4'd9, 1'b0, 16'h0, n, bits, 1'b0);
    tick;

    // Synchronous reset in the middle of a word.
    mode = 4'd3; word = 16'hA5A5; en = 1'b1;
    tick; tick;
    repeat (3) begin neg = 1'b1; tick; neg = 1'b0; end
    rst = 1'b1; en = 1'b0;
    tick;
    rst = 1'b0;
    check_out("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    check_out("rst_after", 1'b1, 1'b0, 1'b0, 1'b0);
    m_crc = 5'h1F; m_word = 16'h0;
    do_mode(4'd9, 1'b0, 16'h0, 5, 16'hF800, 1'b0);
    tick;

    // Randomized mode sequences against the reference model.
    keep = 1'b0;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       m = 4'd0;
        1, 2:    m = 4'd3;
        3:       m = 4'd6;
        4:       m = 4'd8;
        default: m = 4'd9;
      endcase
      if (!keep && $urandom_range(0, 4) == 0) begin
        crc_init = 1'b1; tick; crc_init = 1'b0;
        m_crc = 5'h1F;
      end
      w = 16'($urandom);
      model_expect(m, 1'($urandom), w, n, bits);
      keep = 1'($urandom);
      do_mode(m, bits[15], w, n, bits, keep);
      model_commit(m, w, 16);
      if (!keep) begin
        tick;
        check_out("rnd_idle", 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    if (keep) begin
      en = 1'b0;
      tick;
    end
    model_expect(4'd9, 1'b0, 16'h0, n, bits);
    do_mode(4'd9, 1'b0, 16'h0, n, bits, 1'b0);
    tick;
    check_out("final_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
